// File: rtl/uart_tx_stream.sv
// 8N1 UART transmitter that drains a show-ahead byte FIFO.
// Pops each byte with a one-cycle read pulse and sends frames back-to-back.
module uart_tx_stream #(
  parameter int unsigned CLK_FREQ   = 27000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_read_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_tx_stream: CLK_FREQ/BAUD must be at least 2");
    end
  endgenerate

  logic [1:0]            state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [IDX_W-1:0]      idx, idx_nxt;
  logic [DATA_WIDTH-1:0] shift, shift_nxt;
  logic                  tx_nxt, rd_nxt, busy_nxt, done_nxt;
  logic                  bit_end;

  // State and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      idx          <= '0;
      shift        <= '0;
      tx           <= 1'b1;
      fifo_read_en <= 1'b0;
      busy         <= 1'b0;
      tx_done      <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      idx          <= idx_nxt;
      shift        <= shift_nxt;
      tx           <= tx_nxt;
      fifo_read_en <= rd_nxt;
      busy         <= busy_nxt;
      tx_done      <= done_nxt;
    end
  end

  // Next-state and next-output logic; read_en and tx_done default low for one-cycle pulses.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    shift_nxt = shift;
    tx_nxt    = tx;
    rd_nxt    = 1'b0;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    bit_end   = (cnt == CNT_W'(CLKS_PER_BIT - 1));

    case (state)
      S_IDLE: begin
        tx_nxt = 1'b1;
        if (!fifo_empty) begin
          shift_nxt = fifo_data;
          tx_nxt    = 1'b0;
          busy_nxt  = 1'b1;
          rd_nxt    = 1'b1;
          cnt_nxt   = '0;
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_nxt   = '0;
          idx_nxt   = '0;
          tx_nxt    = shift[0];
          state_nxt = S_DATA;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_nxt = '0;
          if (idx == IDX_W'(DATA_WIDTH - 1)) begin
            tx_nxt    = 1'b1;
            state_nxt = S_STOP;
          end else begin
            shift_nxt = shift >> 1;
            tx_nxt    = shift_nxt[0];
            idx_nxt   = idx + IDX_W'(1);
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_nxt   = '0;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Directed bench for uart_tx_stream at 10 clocks per bit, with a small show-ahead FIFO model.
module tb_uart_tx_stream;

  logic       clk;
  logic       reset_n;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_read_en;
  logic       tx;
  logic       busy;
  logic       tx_done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pops  = 0;
  int illegal_pops = 0;

  logic [7:0] mem [0:15];
  int wr_ptr = 0;
  int rd_ptr = 0;

  uart_tx_stream #(
    .CLK_FREQ  (1000000),
    .BAUD      (100000),
    .DATA_WIDTH(8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .fifo_empty  (fifo_empty),
    .fifo_data   (fifo_data),
    .fifo_read_en(fifo_read_en),
    .tx          (tx),
    .busy        (busy),
    .tx_done     (tx_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_data  = mem[rd_ptr[3:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_read_en) begin
      rd_ptr <= rd_ptr + 1;
      pops   <= pops + 1;
    end
  end

  always @(negedge clk) begin
    if (fifo_read_en && fifo_empty) illegal_pops <= illegal_pops + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[3:0]] = b;
    wr_ptr++;
  endtask

  // Called at a negedge; returns at the first negedge where tx is low.
  task automatic wait_start(input string tag, output int sc);
    int n = 0;
    while (tx !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (tx !== 1'b0) check({tag, "_start_timeout"}, 32'd1, 32'd0);
    sc = cyc;
  endtask

  // Samples a whole frame each cycle, then the done cycle and the cycle after it.
  task automatic run_frame(input string tag, input logic [7:0] data, input bit late,
                           output int sc);
    int errs = 0;
    logic [7:0] rx = 8'h00;
    logic exp_tx;
    wait_start(tag, sc);
    for (int i = 0; i < 100; i++) begin
      if (i > 0) @(negedge clk);
      if (i < 10)      exp_tx = 1'b0;
      else if (i < 90) exp_tx = data[(i / 10) - 1];
      else             exp_tx = 1'b1;
      if (tx !== exp_tx || busy !== 1'b1 || tx_done !== 1'b0) errs++;
      if ((i % 10) == 5 && i >= 15 && i < 90) rx[(i / 10) - 1] = tx;
      if (late && i == 92) push(8'hC3);
    end
    check({tag, "_bits"}, 32'(errs), 32'd0);
    check({tag, "_byte"}, 32'(rx), 32'(data));
    @(negedge clk);
    check({tag, "_done"}, {29'd0, tx_done, busy, tx}, {29'd0, 3'b101});
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'd0, tx_done}, 32'd0);
  endtask

  initial begin
    int s1, s2, s3, p0, errs;
    reset_n = 1'b0;
    push(8'h48);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("reset_out", {28'd0, tx, fifo_read_en, busy, tx_done}, {28'd0, 4'b1000});
    end
    check("reset_nopop", 32'(pops), 32'd0);
    reset_n = 1'b1;

    run_frame("single", 8'h48, 1'b0, s1);
    check("single_pops", 32'(pops), 32'd1);

    errs = 0;
    p0 = pops;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) errs++;
    end
    check("empty_idle", 32'(errs), 32'd0);
    check("empty_pops", 32'(pops - p0), 32'd0);

    p0 = pops;
    push(8'h55);
    push(8'hAA);
    push(8'h00);
    run_frame("burst0", 8'h55, 1'b0, s1);
    run_frame("burst1", 8'hAA, 1'b0, s2);
    run_frame("burst2", 8'h00, 1'b0, s3);
    check("burst_gap01", 32'(s2 - s1), 32'd101);
    check("burst_gap12", 32'(s3 - s2), 32'd101);
    check("burst_pops", 32'(pops - p0), 32'd3);
    check("burst_illegal", 32'(illegal_pops), 32'd0);

    p0 = pops;
    push(8'hFF);
    wait_start("midrst", s1);
    repeat (44) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check("midrst_async", {29'd0, tx, busy, fifo_read_en}, {29'd0, 3'b100});
    push(8'h0F);
    @(negedge clk);
    reset_n = 1'b1;
    run_frame("after_rst", 8'h0F, 1'b0, s2);
    check("midrst_pops", 32'(pops - p0), 32'd2);

    push(8'h3C);
    run_frame("late_cur", 8'h3C, 1'b1, s1);
    run_frame("late_nxt", 8'hC3, 1'b0, s2);
    check("late_gap", 32'(s2 - s1), 32'd101);
    check("final_illegal", 32'(illegal_pops), 32'd0);
    check("final_drained", {31'd0, fifo_empty}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
